// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational n-bit ALU between two requesters.
// The winner's operands are latched in IDLE, executed in EXEC and reported in DONE.

module alu_core #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [1:0]   op,
  output logic [n-1:0] y
);

  always_comb begin
    case (op)
      2'b00:   y = a + b;
      2'b01:   y = a | b;
      2'b10:   y = a - b;
      default: y = a ^ b;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [n-1:0] a0,
  input  logic [n-1:0] b0,
  input  logic [n-1:0] a1,
  input  logic [n-1:0] b1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [n-1:0] result,
  output logic         zero,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t       state;
  state_t       state_next;
  logic         win;
  logic         last;
  logic         pick;
  logic [n-1:0] opr_a;
  logic [n-1:0] opr_b;
  logic [1:0]   opr_op;
  logic [n-1:0] alu_y;

  // Under contention the requester that did not win last time is chosen.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last;
    end else if (!req0) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs decode only the state and winner registers, so none follow the inputs.
  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        gnt0       = ~win;
        gnt1       = win;
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done0      = ~win;
        done1      = win;
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  alu_core #(.n(n)) u_alu (
    .a  (opr_a),
    .b  (opr_b),
    .op (opr_op),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last   <= 1'b1;
      win    <= 1'b0;
      opr_a  <= '0;
      opr_b  <= '0;
      opr_op <= 2'b00;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        win    <= pick;
        last   <= pick;
        opr_a  <= pick ? a1 : a0;
        opr_b  <= pick ? b1 : b0;
        opr_op <= pick ? op1 : op0;
      end
      if (state == EXEC) begin
        result <= alu_y;
        zero   <= (alu_y == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter with a queue-based scoreboard
// fed by a transaction-level model of arbitration and arithmetic.

module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic       gnt0, gnt1, done0, done1, busy, zero;
  logic [3:0] result;

  logic       w_req;
  logic [7:0] w_a, w_b;
  logic [1:0] w_op;
  logic       w_gnt0, w_gnt1, w_done0, w_done1, w_busy, w_zero;
  logic [7:0] w_result;

  always #5 clk = ~clk;

  alu_arbiter #(.n(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .busy(busy)
  );

  alu_arbiter #(.n(8)) dut_wide (
    .clk(clk), .rst(rst), .req0(w_req), .req1(1'b0),
    .a0(w_a), .b0(w_b), .a1(8'h00), .b1(8'h00), .op0(w_op), .op1(2'b00),
    .gnt0(w_gnt0), .gnt1(w_gnt1), .done0(w_done0), .done1(w_done1),
    .result(w_result), .zero(w_zero), .busy(w_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int id;
    int res;
    int cyc;
  } txn_t;

  txn_t gq[$];
  txn_t dq[$];
  int   cyc        = 0;
  int   model_wait = 0;
  int   last_win   = 1;
  int   held_res   = 0;
  int   pend_res   = 0;
  bit   mon_en     = 1'b0;

  function automatic int ref_alu(input int op, input int a, input int b, input int width);
    int m = 1 << width;
    case (op)
      0:       return (a + b) % m;
      1:       return a | b;
      2:       return (a - b + m) % m;
      default: return a ^ b;
    endcase
  endfunction

  // Reference model: a request seen while the unit is free starts a 3-cycle job.
  always @(posedge clk) begin
    txn_t t;
    int   win;
    cyc++;
    if (rst) begin
      model_wait = 0;
      last_win   = 1;
      held_res   = 0;
      gq.delete();
      dq.delete();
      mon_en     = 1'b1;
    end else if (model_wait > 0) begin
      if (model_wait == 2) held_res = pend_res;
      model_wait--;
    end else if (req0 || req1) begin
      win      = (req0 && req1) ? 1 - last_win : (req0 ? 0 : 1);
      last_win = win;
      pend_res = win ? ref_alu(int'(op1), int'(a1), int'(b1), 4)
                     : ref_alu(int'(op0), int'(a0), int'(b0), 4);
      t.id  = win;
      t.res = pend_res;
      t.cyc = cyc;
      gq.push_back(t);
      t.cyc = cyc + 1;
      dq.push_back(t);
      model_wait = 2;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant or completion.
  always @(negedge clk) begin
    txn_t t;
    if (mon_en) begin
      check_output("busy", busy, model_wait > 0);
      check_output("result_hold", result, held_res);
      check_output("zero_hold", zero, held_res == 0);
      check_output("gnt_onehot", gnt0 & gnt1, 0);
      check_output("done_onehot", done0 & done1, 0);
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) begin
          check_output("gnt_unexpected", {gnt1, gnt0}, 0);
        end else begin
          t = gq.pop_front();
          check_output("gnt_id", gnt1, t.id);
          check_output("gnt_cycle", cyc, t.cyc);
        end
      end
      if (done0 || done1) begin
        if (dq.size() == 0) begin
          check_output("done_unexpected", {done1, done0}, 0);
        end else begin
          t = dq.pop_front();
          check_output("done_id", done1, t.id);
          check_output("done_cycle", cyc, t.cyc);
          check_output("done_result", result, t.res);
        end
      end
    end
  end

  task automatic apply_stimulus(input bit id, input logic [3:0] a, input logic [3:0] b,
                                input logic [1:0] op);
    if (id) begin
      a1 = a; b1 = b; op1 = op; req1 = 1'b1;
    end else begin
      a0 = a; b0 = b; op0 = op; req0 = 1'b1;
    end
  endtask

  task automatic wait_gnt(input bit id);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(id ? gnt1 : gnt0) && k < 10);
    check_output(id ? "gnt1_seen" : "gnt0_seen", id ? gnt1 : gnt0, 1);
    if (id) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  initial begin
    int seq[$];
    int gcy[$];
    int k;

    rst = 1'b1;
    req0 = 1'b1; a0 = 4'h3; b0 = 4'h5; op0 = 2'b10;
    req1 = 1'b1; a1 = 4'hA; b1 = 4'h5; op1 = 2'b11;
    w_req = 1'b0; w_a = 8'h00; w_b = 8'h00; w_op = 2'b00;
    repeat (3) @(negedge clk);
    check_output("rst_flags", {gnt1, gnt0, done1, done0, busy}, 0);
    check_output("rst_result", result, 0);
    check_output("rst_zero", zero, 1);
    check_output("rst_wide", {w_busy, w_zero, w_result}, 10'h100);

    // Both requesters held high across four back-to-back operations.
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (gnt0) begin seq.push_back(0); gcy.push_back(cyc); end
      if (gnt1) begin seq.push_back(1); gcy.push_back(cyc); end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check_output("contention_count", seq.size(), 4);
    for (int i = 0; i < seq.size(); i++) check_output("contention_order", seq[i], i % 2);
    for (int i = 1; i < gcy.size(); i++) check_output("grant_spacing", gcy[i] - gcy[i-1], 3);

    repeat (3) @(negedge clk);
    apply_stimulus(0, 4'hF, 4'h1, 2'b00);
    wait_gnt(0);
    @(negedge clk);
    check_output("addwrap_done", done0, 1);
    check_output("addwrap_result", {zero, result}, 5'h10);

    repeat (2) @(negedge clk);
    apply_stimulus(1, 4'h3, 4'h8, 2'b01);
    wait_gnt(1);
    a1 = 4'h0;
    @(negedge clk);
    check_output("opchange_done", done1, 1);
    check_output("opchange_result", result, 4'hB);

    repeat (2) @(negedge clk);
    apply_stimulus(0, 4'h1, 4'h2, 2'b00);
    wait_gnt(0);
    rst = 1'b1;
    @(negedge clk);
    check_output("rstexec_done", done0, 0);
    check_output("rstexec_busy", busy, 0);
    check_output("rstexec_result", result, 0);
    rst = 1'b0;
    apply_stimulus(0, 4'h5, 4'h6, 2'b00);
    wait_gnt(0);
    @(negedge clk);
    check_output("after_rst_done", done0, 1);
    check_output("after_rst_result", result, 4'hB);

    // Random traffic; operands are scrambled right after capture.
    repeat (400) begin
      @(negedge clk);
      if (gnt0) begin
        req0 = 1'b0; a0 = 4'($urandom); b0 = 4'($urandom);
      end else if (!req0 && $urandom_range(2) == 0) begin
        apply_stimulus(0, 4'($urandom), 4'($urandom), 2'($urandom));
      end
      if (gnt1) begin
        req1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
      end else if (!req1 && $urandom_range(2) == 0) begin
        apply_stimulus(1, 4'($urandom), 4'($urandom), 2'($urandom));
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (8) @(negedge clk);
    check_output("drain_gnt_queue", gq.size(), 0);
    check_output("drain_done_queue", dq.size(), 0);

    // Eight-bit instance: subtract wrap, then add wrap to zero.
    w_a = 8'h00; w_b = 8'h01; w_op = 2'b10; w_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!w_gnt0 && k < 10);
    check_output("wide_gnt", w_gnt0, 1);
    w_req = 1'b0;
    @(negedge clk);
    check_output("wide_done", w_done0, 1);
    check_output("wide_sub", {w_zero, w_result}, 9'h0FF);
    repeat (2) begin
      @(negedge clk);
      check_output("wide_idle_busy", w_busy, 0);
    end
    w_a = 8'h80; w_b = 8'h80; w_op = 2'b00; w_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!w_gnt0 && k < 10);
    check_output("wide_gnt2", w_gnt0, 1);
    w_req = 1'b0;
    @(negedge clk);
    check_output("wide_done2", w_done0, 1);
    check_output("wide_add", {w_zero, w_result}, 9'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one n-bit ALU between two requesters under round-robin arbitration. Each request carries its own operands and opcode. The block latches the winning request, executes it on the ALU, and returns a registered result with a done pulse to the winner. It sits between two independent datapath clients and the team's combinational n-bit ALU, which it instantiates internally.

## Interface
- `n`, default 4: operand and result width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req0`, `req1`  in  1: request from requester 0 / 1. Held high until the matching `gnt` is seen.
- `a0`, `b0`, `a1`, `b1`  in  n: operands per requester. Must be stable while the matching `req` is high.
- `op0`, `op1`  in  2: opcode per requester.
  - 00 = add
  - 01 = OR
  - 10 = subtract (a-b)
  - 11 = XOR
- `gnt0`, `gnt1`  out  1: one-cycle pulse; operands of that requester have been captured.
- `done0`, `done1`  out  1: one-cycle pulse; `result` is valid for that requester.
- `result`  out  n: registered ALU result. Holds its value until the next completion.
- `zero`  out  1: registered; high when `result` == 0. Updated together with `result`.
- `busy`  out  1: high in EXEC and DONE.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE, no request pending: remain in IDLE.
- IDLE, at least one request pending, on the clock edge:
  - Pick a winner.
  - Latch its `a`, `b`, `op` into operand registers.
  - Record the winner id.
  - Update the last-winner pointer.
  - Go to EXEC.
- EXEC:
  - `gnt` of the winner is high for exactly this cycle.
  - The ALU evaluates the latched operands.
  - At the edge, the ALU output is registered into `result` and `zero`; go to DONE.
- DONE:
  - `done` of the winner is high for exactly this cycle.
  - At the edge, go to IDLE.
  - Requests are not sampled in EXEC or DONE.
- Arbitration:
  - Single request: that requester wins.
  - Both requesting: the requester that is not the last winner wins.
  - The last-winner pointer resets to 1, so requester 0 wins the first contention.
- Arithmetic:
  - All results are truncated to n bits (mod 2^n).
  - Add discards the carry.
  - Subtract wraps: 0 - 1 = 2^n - 1.
  - No flags other than `zero`.
- Operands come only from the latched registers. Input changes after capture do not affect the result.
- Requester obligation: drop `req` in the cycle after seeing `gnt`. A `req` still high when IDLE is next entered counts as a new request.
- Reset, synchronous, at any state:
  - FSM to IDLE, pointer to 1.
  - `result` = 0, `zero` = 1.
  - All `gnt`/`done`/`busy` outputs = 0.
  - An in-flight operation is dropped with no `done` pulse.

## Timing
- Request sampled at edge T (FSM in IDLE):
  - `gnt` high during cycle T..T+1.
  - `result` valid and `done` high during cycle T+1..T+2.
- Latency from capture edge to `done`: 2 cycles.
- Throughput: one operation per 3 cycles under continuous requests.
- A pending request may first be sampled at the edge that ends DONE+1, i.e. the first edge in IDLE.
- `gnt0`/`gnt1` never assert together. The same holds for `done0`/`done1`.
- `gnt0`, `gnt1`, `done0`, `done1`, `busy`, `result` and `zero` are all decoded from or held in registers. No combinational path runs from inputs to outputs.
- `busy` is low in the first cycle after reset deassertion.

## Test plan
- Reset with `req0`=`req1`=1 held:
  - All outputs are 0 except `zero`=1.
  - After `rst` falls, the first grant goes to requester 0.
- Single request, add wrap:
  - `req0`, `a0`=4'hF, `b0`=4'h1, `op0`=00.
  - `gnt0` one cycle after capture, then `done0`, with `result`=4'h0 and `zero`=1.
- Simultaneous requests, held continuously:
  - req0: op 10, 3 - 5. req1: op 11, 4'hA ^ 4'h5.
  - Grants alternate 0, 1, 0, 1.
  - `result`=4'hE with `done0`; `result`=4'hF with `done1`.
  - Spacing of 3 cycles between grants.
- Operand change after grant:
  - req1, op 01, 4'h3 | 4'h8; change `a1` to 0 in the cycle after `gnt1`.
  - `result`=4'hB.
- Reset asserted during EXEC:
  - No `done` pulse.
  - `result`=0, `busy`=0 on the next cycle.
  - The subsequent request completes normally.
- Parameter `n`=8:
  - Subtract 8'h00 - 8'h01 gives `result`=8'hFF, `zero`=0.
  - Idle spacing between requests: `busy` low in IDLE.
